reg_cmd_sequencer: RTL and testbench

Command-driven initiator for the 2-bit register control interface (NONE/LOAD/INCR/CLR). Accepts one command at a time over a valid/ready handshake and drives `ctrl`/`data` into a `parallel_register` of matching `WIDTH`. It reads the register's output back to terminate count operations, and pulses `done` when each command completes. It sits between a host/control FSM and the datapath register.

---
 rtl/reg_cmd_sequencer_pkg.sv | 27 ++
 rtl/parallel_register.sv | 28 ++
 rtl/reg_cmd_sequencer.sv | 92 +++++++++
 tb/tb_reg_cmd_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_cmd_sequencer_pkg.sv
// Shared encodings for the register control interface and the command sequencer.
// The ctrl encoding is common to the sequencer and the parallel_register it drives.
package reg_cmd_sequencer_pkg;

  typedef enum logic [1:0] {
    CTRL_NONE = 2'd0,
    CTRL_LOAD = 2'd1,
    CTRL_INCR = 2'd2,
    CTRL_CLR  = 2'd3
  } ctrl_e;

  typedef enum logic [1:0] {
    OP_LOAD     = 2'd0,
    OP_CLEAR    = 2'd1,
    OP_COUNT_TO = 2'd2,
    OP_RAMP     = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CLEAR = 3'd2,
    ST_COUNT = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/parallel_register.sv
// Loadable/incrementable/clearable register driven over the 2-bit ctrl interface.
// The output is registered, so a combinational ctrl decision from data_out forms no loop.
module parallel_register
  import reg_cmd_sequencer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             async_nreset,
  input  logic [1:0]       ctrl,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      data_out <= '0;
    end else begin
      case (ctrl_e'(ctrl))
        CTRL_LOAD: data_out <= data_in;
        CTRL_INCR: data_out <= data_out + WIDTH'(1);
        CTRL_CLR:  data_out <= '0;
        default:   data_out <= data_out;
      endcase
    end
  end

endmodule

// File: rtl/reg_cmd_sequencer.sv
// Command-driven initiator for a parallel_register: LOAD, CLEAR, COUNT_TO and RAMP,
// terminating counts on the register's own output and pulsing done on completion.
module reg_cmd_sequencer
  import reg_cmd_sequencer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             async_nreset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_abort,
  input  logic [WIDTH-1:0] reg_value,
  output logic [1:0]       reg_ctrl,
  output logic [WIDTH-1:0] reg_data,
  output logic             busy,
  output logic             done
);

  state_e           state_reg;
  state_e           state_next;
  logic [WIDTH-1:0] target_reg;
  logic             is_ramp_reg;
  ctrl_e            ctrl_next;
  logic             accept;
  logic             at_target;

  assign accept    = cmd_valid && (state_reg == ST_IDLE);
  assign at_target = (reg_value == target_reg);

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      state_reg   <= ST_IDLE;
      target_reg  <= '0;
      is_ramp_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        target_reg  <= cmd_data;
        is_ramp_reg <= (op_e'(cmd_op) == OP_RAMP);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    ctrl_next  = CTRL_NONE;
    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (op_e'(cmd_op))
            OP_LOAD:     state_next = ST_LOAD;
            OP_CLEAR:    state_next = ST_CLEAR;
            OP_COUNT_TO: state_next = ST_COUNT;
            default:     state_next = ST_CLEAR;
          endcase
        end
      end
      ST_LOAD: begin
        ctrl_next  = CTRL_LOAD;
        state_next = ST_DONE;
      end
      ST_CLEAR: begin
        ctrl_next  = CTRL_CLR;
        state_next = is_ramp_reg ? ST_COUNT : ST_DONE;
      end
      ST_COUNT: begin
        // Stop incrementing in the very cycle the registered output reaches target.
        if (at_target) begin
          state_next = ST_DONE;
        end else begin
          ctrl_next = CTRL_INCR;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (cmd_abort && (state_reg != ST_IDLE)) begin
      ctrl_next  = CTRL_NONE;
      state_next = ST_IDLE;
    end
  end

  assign reg_ctrl  = ctrl_next;
  assign reg_data  = target_reg;
  assign cmd_ready = (state_reg == ST_IDLE);
  assign busy      = (state_reg != ST_IDLE);
  assign done      = (state_reg == ST_DONE);

endmodule

// File: tb/tb_reg_cmd_sequencer.sv
// Directed bench for reg_cmd_sequencer driving a real parallel_register; a per-cycle
// scoreboard of expected ctrl/done/busy/value is filled at each accept and drained by a monitor.
module tb_reg_cmd_sequencer;
  import reg_cmd_sequencer_pkg::*;

  localparam int WIDTH = 8;

  logic             clk;
  logic             async_nreset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_abort;
  logic [WIDTH-1:0] reg_value;
  logic [1:0]       reg_ctrl;
  logic [WIDTH-1:0] reg_data;
  logic             busy;
  logic             done;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;
  logic [WIDTH-1:0] model_reg = '0;

  typedef struct {
    string      tag;
    logic [1:0] ctrl;
    logic       dn;
    logic       chk;
    logic [7:0] val;
  } exp_t;

  exp_t exp_q[$];

  reg_cmd_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .async_nreset(async_nreset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .cmd_abort(cmd_abort), .reg_value(reg_value), .reg_ctrl(reg_ctrl), .reg_data(reg_data),
    .busy(busy), .done(done)
  );

  parallel_register #(.WIDTH(WIDTH)) u_reg (
    .clk(clk), .async_nreset(async_nreset), .ctrl(reg_ctrl),
    .data_in(reg_data), .data_out(reg_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [1:0] c, input logic dn,
                      input logic chk, input logic [7:0] val);
    exp_t e;
    e.tag = tag; e.ctrl = c; e.dn = dn; e.chk = chk; e.val = val;
    exp_q.push_back(e);
  endtask

  // Reference model: per-cycle expectations from the accept edge onward.
  task automatic expect_cmd(input logic [1:0] op, input logic [7:0] data);
    int n;
    case (op)
      OP_LOAD: begin
        push("load.ctl", CTRL_LOAD, 1'b0, 1'b0, 8'h00);
        push("load.done", CTRL_NONE, 1'b1, 1'b1, data);
      end
      OP_CLEAR: begin
        push("clear.ctl", CTRL_CLR, 1'b0, 1'b0, 8'h00);
        push("clear.done", CTRL_NONE, 1'b1, 1'b1, 8'h00);
      end
      OP_COUNT_TO: begin
        n = int'(8'(data - model_reg));
        for (int i = 0; i < n; i++) push($sformatf("cnt.incr%0d", i), CTRL_INCR, 1'b0, 1'b0, 8'h00);
        push("cnt.eq", CTRL_NONE, 1'b0, 1'b1, data);
        push("cnt.done", CTRL_NONE, 1'b1, 1'b1, data);
      end
      default: begin
        push("ramp.clr", CTRL_CLR, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < int'(data); i++) push($sformatf("ramp.incr%0d", i), CTRL_INCR, 1'b0, 1'b0, 8'h00);
        push("ramp.eq", CTRL_NONE, 1'b0, 1'b1, data);
        push("ramp.done", CTRL_NONE, 1'b1, 1'b1, data);
      end
    endcase
    model_reg = (op == OP_CLEAR) ? 8'h00 : data;
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] data);
    @(negedge clk);
    check("issue.ready", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom_range(3, 0));
    cmd_data  = 8'($urandom);
    expect_cmd(op, data);
    $display("cmd op=%0d data=%02h queued=%0d", op, data, exp_q.size());
  endtask

  task automatic drain(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(posedge clk);
      if (exp_q.size() == 0) break;
    end
    if (k == budget) begin
      checks++;
      errors++;
      $display("FAIL drain.timeout: observed=%0d pending expected=0 pending", exp_q.size());
      exp_q.delete();
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("%s.ctrl", e.tag), {30'd0, reg_ctrl}, {30'd0, e.ctrl});
        check($sformatf("%s.done", e.tag), {31'd0, done}, {31'd0, e.dn});
        check($sformatf("%s.busy", e.tag), {31'd0, busy}, 32'd1);
        if (e.chk) check($sformatf("%s.val", e.tag), {24'd0, reg_value}, {24'd0, e.val});
      end else begin
        check("idle.done", {31'd0, done}, 32'd0);
      end
    end
  end

  initial begin
    async_nreset = 1'b0;
    cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = '0; cmd_abort = 1'b0;
    #12;
    check("rst.ctrl",  {30'd0, reg_ctrl}, {30'd0, CTRL_NONE});
    check("rst.data",  {24'd0, reg_data}, 32'd0);
    check("rst.busy",  {31'd0, busy}, 32'd0);
    check("rst.done",  {31'd0, done}, 32'd0);
    check("rst.ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    async_nreset = 1'b1;
    mon_en = 1'b1;

    issue(OP_LOAD, 8'hA5);
    drain(20);
    @(negedge clk);
    check("load.ready_back", {31'd0, cmd_ready}, 32'd1);

    issue(OP_LOAD, 8'h05);     drain(20);
    issue(OP_COUNT_TO, 8'h08); drain(20);
    issue(OP_LOAD, 8'hFE);     drain(20);
    issue(OP_COUNT_TO, 8'h01); drain(20);
    issue(OP_COUNT_TO, 8'h01); drain(20);

    // RAMP with a second command held pending for its whole duration.
    issue(OP_LOAD, 8'h77);     drain(20);
    issue(OP_RAMP, 8'h04);
    cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_data = 8'h33;
    drain(30);
    @(negedge clk);
    check("pend.ready", {31'd0, cmd_ready}, 32'd1);
    check("pend.val",   {24'd0, reg_value}, 32'h04);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    expect_cmd(OP_LOAD, 8'h33);
    drain(20);

    // Abort COUNT_TO 0x10 after two increments.
    issue(OP_LOAD, 8'h00); drain(20);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_COUNT_TO; cmd_data = 8'h10;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    push("abt.incr0", CTRL_INCR, 1'b0, 1'b0, 8'h00);
    push("abt.incr1", CTRL_INCR, 1'b0, 1'b0, 8'h00);
    @(posedge clk);
    @(posedge clk);
    #1;
    cmd_abort = 1'b1;
    @(negedge clk);
    check("abt.ctrl", {30'd0, reg_ctrl}, {30'd0, CTRL_NONE});
    check("abt.busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    cmd_abort = 1'b0;
    model_reg = 8'h02;
    @(negedge clk);
    check("abt.idle",  {31'd0, busy}, 32'd0);
    check("abt.val",   {24'd0, reg_value}, 32'h02);
    repeat (3) @(negedge clk);
    issue(OP_LOAD, 8'h5A); drain(20);

    // Asynchronous reset in the middle of a long wrapping count.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_COUNT_TO; cmd_data = 8'h50;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    mon_en = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("mid.ctrl_pre", {30'd0, reg_ctrl}, {30'd0, CTRL_INCR});
    async_nreset = 1'b0;
    #1;
    check("mid.ctrl",  {30'd0, reg_ctrl}, {30'd0, CTRL_NONE});
    check("mid.busy",  {31'd0, busy}, 32'd0);
    check("mid.done",  {31'd0, done}, 32'd0);
    check("mid.ready", {31'd0, cmd_ready}, 32'd1);
    check("mid.data",  {24'd0, reg_data}, 32'd0);
    @(negedge clk);
    async_nreset = 1'b1;
    model_reg = 8'h00;
    @(negedge clk);
    check("post.ready", {31'd0, cmd_ready}, 32'd1);
    check("post.ctrl",  {30'd0, reg_ctrl}, {30'd0, CTRL_NONE});
    mon_en = 1'b1;

    issue(OP_LOAD, 8'h3C); drain(20);
    issue(OP_CLEAR, 8'hEE); drain(20);
    issue(OP_RAMP, 8'h00);  drain(20);
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
